seq_gen: RTL and testbench

- Parallel-to-serial stimulus generator that sits directly upstream of the serial sequence detector and drives its single-bit `in` input.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first.
- Each bit is held for a programmable number of clocks, with optional continuous looping.
- Emits a per-bit strobe and an end-of-word pulse so the bench or a downstream checker can align with the detector output.

---
 rtl/seq_gen.sv | 105 ++++++++++
 tb/tb_seq_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// seq_gen: valid/ready word in, MSB-first serial out with per-bit hold of div+1 clocks, optional looping; ports clk reset data_in data_valid data_ready div loop serial_out bit_strobe busy done
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             loop,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, word_q, word_d;
  logic [DIV_W-1:0] period_q, period_d, tick_q, tick_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
  logic accept;
  assign data_ready = (state_q == IDLE) & ~reset;
  assign accept = data_valid & data_ready;
  assign serial_out = sh_q[WIDTH-1];
  assign bit_strobe = strobe_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    word_d = word_q;
    period_d = period_q;
    tick_d = tick_q;
    cnt_d = cnt_q;
    strobe_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      sh_d = '0;
      busy_d = 1'b0;
      if (accept) begin
        state_d = SHIFT;
        sh_d = data_in;
        word_d = data_in;
        period_d = div;
        tick_d = '0;
        cnt_d = LAST;
        strobe_d = 1'b1;
        busy_d = 1'b1;
      end
    end else if (state_q == SHIFT) begin
      tick_d = tick_q + 1'b1;
      if (tick_q == period_q) begin
        tick_d = '0;
        strobe_d = 1'b1;
        if (cnt_q != '0) begin
          sh_d = sh_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else if (loop) begin
          sh_d = word_q;
          cnt_d = LAST;
        end else begin
          state_d = IDLE;
          sh_d = '0;
          strobe_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else begin
      state_d = IDLE;
      sh_d = '0;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      word_q <= '0;
      period_q <= '0;
      tick_q <= '0;
      cnt_q <= '0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      word_q <= word_d;
      period_q <= period_d;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized scoreboard bench for seq_gen with a cycle-timeline reference model
module tb_seq_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_in = '0;
  logic data_valid = 1'b0;
  logic data_ready;
  logic [15:0] div = '0;
  logic loop = 1'b0;
  logic serial_out, bit_strobe, busy, done;
  typedef struct {int cyc; logic b;} exp_t;
  exp_t exp_q[$];
  int done_q[$];
  int cyc = 0;
  int free_at = 0;
  int bs = 0;
  int total = 0;
  int pass = 0;
  bit running = 1'b0;
  logic cur_bit = 1'b0;
  seq_gen dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .div(div), .loop(loop), .serial_out(serial_out),
    .bit_strobe(bit_strobe), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s actual=%0d expected=%0d cycle=%0d", n, act, exp, cyc);
  endtask
  initial begin
    exp_t e;
    int d;
    bit mb;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        mb = (cyc >= bs) && (cyc < free_at);
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          chk("strobe_missing", exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        while (done_q.size() != 0 && done_q[0] < cyc) begin
          chk("done_missing", done_q[0], cyc);
          void'(done_q.pop_front());
        end
        if (bit_strobe) begin
          if (exp_q.size() == 0) chk("strobe_extra", bit_strobe, 0);
          else begin
            e = exp_q.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_bit", serial_out, e.b);
            cur_bit = e.b;
          end
        end else if (mb) chk("hold_bit", serial_out, cur_bit);
        if (done) begin
          if (done_q.size() == 0) chk("done_extra", done, 0);
          else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d);
          end
        end
        chk("busy", busy, mb);
        chk("ready", data_ready, !mb && !reset);
        if (!mb) chk("idle_serial", serial_out, 0);
      end
    end
  end
  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] w, input int d, input int reps, input int abort_bit);
    int a, p, e;
    while (cyc < free_at) @(negedge clk);
    chk("ready_at_offer", data_ready, 1);
    data_in = w;
    div = 16'(d);
    loop = reps > 1;
    data_valid = 1'b1;
    a = cyc + 1;
    p = 8 * (d + 1);
    for (int j = 0; j < reps; j++)
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{a + j * p + i * (d + 1), w[7-i]});
    done_q.push_back(a + reps * p);
    bs = a;
    free_at = a + reps * p;
    forever begin
      @(negedge clk);
      if (cyc >= free_at) break;
      if (abort_bit >= 0 && cyc == a + abort_bit * (d + 1)) begin
        reset = 1'b1;
        data_valid = 1'b0;
        exp_q.delete();
        done_q.delete();
        free_at = cyc + 1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_serial", serial_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        #1 chk("abort_ready", data_ready, 1);
        break;
      end
      e = cyc + 1;
      loop = ((e - a) % p == 0) ? ((e - a) / p < reps) : 1'($urandom);
      data_valid = ($urandom % 3) == 0;
      data_in = 8'($urandom);
      div = 16'($urandom);
    end
    data_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_serial", serial_out, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", data_ready, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", data_ready, 1);
    free_at = cyc;
    bs = cyc;
    running = 1'b1;
    send(8'b00101011, 0, 1, -1);
    idle(2);
    send(8'b00101011, 3, 1, -1);
    idle(1);
    send(8'hA5, 0, 4, -1);
    idle(2);
    send(8'hFF, 0, 1, -1);
    send(8'h00, 0, 1, -1);
    idle(3);
    send(8'hC3, 1, 1, 4);
    send(8'h5A, 1, 1, -1);
    for (int t = 0; t < 25; t++) begin
      idle($urandom_range(0, 3));
      send(8'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), -1);
    end
    idle(4);
    running = 1'b0;
    chk("leftover", exp_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
